// File: rtl/pmp_check_pipe.sv
// Two-stage PMP checker: S1 holds the request and evaluates per-entry hits,
// S2 holds the priority-selected result and permission driving the response.

module pmp_entry_match #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [ADDR_WIDTH-1:0] ent_addr,
   input  logic [ADDR_WIDTH-1:0] prev_addr,
   input  logic [ADDR_WIDTH-1:0] napot_mask,
   output logic                  hit
);
   always_comb begin
      hit = 1'b0;
      unique case (mode)
         // an empty TOR range (prev >= addr) falls out of this compare naturally
         2'b01:   hit = (req_addr >= prev_addr) && (req_addr < ent_addr);
         2'b10:   hit = (req_addr == ent_addr);
         2'b11:   hit = ((req_addr & napot_mask) == (ent_addr & napot_mask));
         default: hit = 1'b0;
      endcase
   end
endmodule

module pmp_check_pipe #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_ENTRY  = 8,
   parameter int IDX_W      = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_wr_en,
   input  logic [IDX_W-1:0]      cfg_wr_idx,
   input  logic [7:0]            cfg_wr_cfg,
   input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_type,
   input  logic                  req_priv_m,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic                  rsp_allow,
   output logic                  rsp_hit,
   output logic [IDX_W-1:0]      rsp_hit_idx
);
   logic [NUM_ENTRY-1:0][7:0]            cfg_q;
   logic [NUM_ENTRY-1:0][ADDR_WIDTH-1:0] addr_q;
   logic [NUM_ENTRY-1:0][ADDR_WIDTH-1:0] mask_q;
   logic [NUM_ENTRY-1:0]                 lock;
   logic [NUM_ENTRY-1:0]                 hit_vec;
   logic                                 wr_ok;
   logic                                 unused_cfg;

   logic                  s1_vld, s2_vld, adv;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [1:0]            s1_type;
   logic                  s1_priv;
   logic                  sel_hit, sel_allow;
   logic [IDX_W-1:0]      sel_idx;
   logic [7:0]            sel_cfg;

   // ---------------- entry table ----------------
   always_comb begin
      wr_ok = 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++)
         if (cfg_wr_idx == IDX_W'(i)) wr_ok = !lock[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q  <= '0;
         addr_q <= '0;
         mask_q <= '0;
      end else if (cfg_wr_en && wr_ok) begin
         cfg_q[cfg_wr_idx]  <= cfg_wr_cfg;
         addr_q[cfg_wr_idx] <= cfg_wr_addr;
         mask_q[cfg_wr_idx] <= ~(cfg_wr_addr ^ (cfg_wr_addr + ADDR_WIDTH'(1)));
      end
   end

   always_comb begin
      unused_cfg = 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++) unused_cfg = unused_cfg ^ (^cfg_q[i][6:5]);
   end

   for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_ent
      logic [ADDR_WIDTH-1:0] prev;
      if (i == 0) begin : g_first
         assign prev = '0;
      end else begin : g_rest
         assign prev = addr_q[i-1];
      end
      // a locked TOR entry above also freezes this entry, since it is its lower bound
      if (i + 1 < NUM_ENTRY) begin : g_lk
         assign lock[i] = cfg_q[i][7] | (cfg_q[i+1][7] & (cfg_q[i+1][4:3] == 2'b01));
      end else begin : g_lk_last
         assign lock[i] = cfg_q[i][7];
      end
      pmp_entry_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
         .mode       (cfg_q[i][4:3]),
         .req_addr   (s1_addr),
         .ent_addr   (addr_q[i]),
         .prev_addr  (prev),
         .napot_mask (mask_q[i]),
         .hit        (hit_vec[i])
      );
   end

   // ---------------- priority select and permission ----------------
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      sel_cfg = '0;
      for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            sel_hit = 1'b1;
            sel_idx = IDX_W'(i);
            sel_cfg = cfg_q[i];
         end
      end
      sel_allow = s1_priv;
      if (sel_hit) begin
         unique case (s1_type)
            2'b00:   sel_allow = sel_cfg[0];
            2'b01:   sel_allow = sel_cfg[1];
            2'b10:   sel_allow = sel_cfg[2];
            default: sel_allow = 1'b0;
         endcase
         if (s1_priv && !sel_cfg[7] && s1_type != 2'b11) sel_allow = 1'b1;
      end
   end

   // ---------------- pipeline ----------------
   assign adv     = !s2_vld | rsp_rdy;
   assign req_rdy = !rst & (!s1_vld | adv);
   assign rsp_vld = s2_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld      <= 1'b0;
         s2_vld      <= 1'b0;
         rsp_allow   <= 1'b0;
         rsp_hit     <= 1'b0;
         rsp_hit_idx <= '0;
      end else begin
         if (req_vld && req_rdy) s1_vld <= 1'b1;
         else if (adv)           s1_vld <= 1'b0;
         if (adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
               rsp_allow   <= sel_allow;
               rsp_hit     <= sel_hit;
               rsp_hit_idx <= sel_idx;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_vld && req_rdy) begin
         s1_addr <= req_addr;
         s1_type <= req_type;
         s1_priv <= req_priv_m;
      end
   end
endmodule
